// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sync_fifo_ctrl.
interface sync_fifo_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 3
) ();
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ren;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    // User side: issues requests, observes data and status.
    modport master (
        output wen, wdata, ren, clr_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  wen, wdata, ren, clr_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH    = 3,
    parameter int unsigned AFULL_THRESH  = 6,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_ctrl_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc_c;
    logic                  rd_acc_c;
    logic [CNT_W-1:0]      count_nxt_c;

    // Acceptance is gated by the registered flags, never by the other request.
    assign wr_acc_c = bus.wen && !bus.full;
    assign rd_acc_c = bus.ren && !bus.empty;

    // Next occupancy; reset forces zero so the flag registers follow it.
    always_comb begin
        count_nxt_c = bus.count;
        if (rst) begin
            count_nxt_c = '0;
        end else begin
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count_nxt_c = bus.count + CNT_W'(1);
                2'b01:   count_nxt_c = bus.count - CNT_W'(1);
                default: count_nxt_c = bus.count;
            endcase
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_c) begin
            mem[wr_ptr] <= bus.wdata;
        end
    end

    // Pointers, count, read port and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.count     <= '0;
            bus.rdata     <= '0;
            bus.rvalid    <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.count  <= count_nxt_c;
            bus.rvalid <= rd_acc_c;
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc_c) begin
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                bus.rdata <= mem[rd_ptr];
            end
            bus.overflow  <= (bus.overflow  && !bus.clr_err) || (bus.wen && bus.full);
            bus.underflow <= (bus.underflow && !bus.clr_err) || (bus.ren && bus.empty);
        end
    end

    // Status flags are a registered decode of the next count, so they always
    // equal a decode of the current count without a combinational output path.
    always_ff @(posedge clk) begin
        bus.full         <= (count_nxt_c == CNT_W'(DEPTH));
        bus.empty        <= (count_nxt_c == '0);
        bus.almost_full  <= (count_nxt_c >= CNT_W'(AFULL_THRESH));
        bus.almost_empty <= (count_nxt_c <= CNT_W'(AEMPTY_THRESH));
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised and directed checking of sync_fifo_ctrl against a queue model.
module tb_sync_fifo_ctrl;
    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst;

    sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state.
    int q[$];
    int exp_rdata  = 0;
    int exp_rvalid = 0;
    int exp_ovf    = 0;
    int exp_unf    = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive, advance model on the edge, compare just after it.
    task automatic step(input int w, input int d, input int r, input int c, input int rs);
        int n;
        bus.wen     = w[0];
        bus.wdata   = DW'(d);
        bus.ren     = r[0];
        bus.clr_err = c[0];
        rst         = rs[0];
        @(posedge clk);
        if (rs != 0) begin
            q.delete();
            exp_rdata  = 0;
            exp_rvalid = 0;
            exp_ovf    = 0;
            exp_unf    = 0;
        end else begin
            n = q.size();
            exp_rvalid = (r != 0 && n > 0) ? 1 : 0;
            if (exp_rvalid != 0) exp_rdata = q.pop_front();
            if (w != 0 && n < DEPTH) q.push_back(d & 15);
            exp_ovf = ((exp_ovf != 0 && c == 0) || (w != 0 && n == DEPTH)) ? 1 : 0;
            exp_unf = ((exp_unf != 0 && c == 0) || (r != 0 && n == 0)) ? 1 : 0;
        end
        #1;
        chk("count",        int'(bus.count),        q.size());
        chk("full",         int'(bus.full),         int'(q.size() == DEPTH));
        chk("empty",        int'(bus.empty),        int'(q.size() == 0));
        chk("almost_full",  int'(bus.almost_full),  int'(q.size() >= AF));
        chk("almost_empty", int'(bus.almost_empty), int'(q.size() <= AE));
        chk("rvalid",       int'(bus.rvalid),       exp_rvalid);
        chk("rdata",        int'(bus.rdata),        exp_rdata);
        chk("overflow",     int'(bus.overflow),     exp_ovf);
        chk("underflow",    int'(bus.underflow),    exp_unf);
    endtask

    initial begin
        int pw;
        int pr;
        bus.wen = 1'b0; bus.wdata = '0; bus.ren = 1'b0; bus.clr_err = 1'b0; rst = 1'b1;

        // Reset with both requests asserted.
        step(1, 5, 1, 0, 1);
        step(1, 5, 1, 0, 1);

        // Fill with 1..8, then an overflowing write of 0xF.
        for (int i = 1; i <= 8; i++) step(1, i, 0, 0, 0);
        step(1, 15, 0, 0, 0);

        // Drain all eight, then one underflowing read.
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0);

        // Clear both sticky errors.
        step(0, 0, 0, 1, 0);

        // Preload four, then concurrent traffic across pointer wrap.
        for (int i = 0; i < 4; i++) step(1, 9 + i, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, $urandom_range(15), 1, 0, 0);

        // Simultaneous request at empty.
        while (q.size() > 0) step(0, 0, 1, 0, 0);
        step(1, 6, 1, 0, 0);

        // Simultaneous request at full.
        while (q.size() < DEPTH) step(1, $urandom_range(15), 0, 0, 0);
        step(1, 3, 1, 0, 0);

        // clr_err coinciding with a new overflow keeps the flag set.
        step(1, 4, 0, 0, 0);
        step(1, 2, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Reset mid-operation at count 5, then a fresh write/read pair.
        while (q.size() > 5) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 10, 0, 0, 0);
        step(0, 0, 1, 0, 0);

        // Random traffic with shifting write/read bias to visit full and empty.
        for (int ph = 0; ph < 20; ph++) begin
            pw = $urandom_range(90, 10);
            pr = $urandom_range(90, 10);
            for (int i = 0; i < 100; i++) begin
                step(int'($urandom_range(99) < pw), $urandom_range(15),
                     int'($urandom_range(99) < pr), int'($urandom_range(15) == 0),
                     int'($urandom_range(199) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
